// File: rtl/serial_slave_port.sv
// serial_slave_port: slave-side responder of the serial master/slave bus.
// Deserialises an MSB-first address (and write data) from the granted master,
// writes to or reads from a local register memory, and serialises read data
// back with bus_ready flow control.
// Optional feature macro: SLAVE_WAIT_STATES_EN inserts WAIT_CYCLES read wait
// states between READ and TX.
module serial_slave_port #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic address,
  input  logic data,
  input  logic valid,
  input  logic write_en,
  input  logic bus_ready,
  output logic ready,
  output logic data_out,
  output logic valid_out
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W) + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_ADDR = 3'd1;
  localparam logic [2:0] S_RX_DATA = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_TX      = 3'd5;
`ifdef SLAVE_WAIT_STATES_EN
  localparam logic [2:0] S_WAIT    = 3'd6;
  localparam int unsigned WAIT_W   = $clog2(WAIT_CYCLES + 1);
`endif

  logic [2:0]            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  op_wr, op_wr_n;
  logic                  ready_n, data_out_n, valid_out_n;
  logic                  beat;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef SLAVE_WAIT_STATES_EN
  logic [WAIT_W-1:0]     wcnt, wcnt_n;
`else
  // WAIT_CYCLES only shapes the design when wait states are compiled in.
  if (WAIT_CYCLES == 0) begin : g_wait_cycles_unused
  end
`endif

  assign beat    = valid && bus_ready;
  assign rd_word = mem[addr];

  // Next-state, shift-register and output decode.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    addr_n      = addr;
    shift_n     = shift;
    op_wr_n     = op_wr;
    data_out_n  = data_out;
    valid_out_n = 1'b0;
`ifdef SLAVE_WAIT_STATES_EN
    wcnt_n      = wcnt;
`endif
    case (state)
      S_IDLE: begin
        if (beat) begin
          addr_n  = {addr[ADDR_WIDTH-2:0], address};
          op_wr_n = write_en;
          state_n = S_RX_ADDR;
        end
      end
      S_RX_ADDR: begin
        // Reads settle the full address for one cycle before the lookup.
        if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
          state_n = S_READ;
        end else if (beat) begin
          addr_n = {addr[ADDR_WIDTH-2:0], address};
          if (op_wr && (cnt == CNT_W'(ADDR_WIDTH - 2))) begin
            state_n = S_RX_DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_RX_DATA: begin
        if (cnt == CNT_W'(DATA_WIDTH)) begin
          state_n = S_WRITE;
        end else if (beat) begin
          shift_n = {shift[DATA_WIDTH-2:0], data};
          cnt_n   = cnt + 1'b1;
        end
      end
      S_WRITE: begin
        state_n = S_IDLE;
      end
      S_READ: begin
`ifdef SLAVE_WAIT_STATES_EN
        shift_n = rd_word;
        wcnt_n  = WAIT_W'(WAIT_CYCLES - 1);
        state_n = S_WAIT;
`else
        data_out_n  = rd_word[DATA_WIDTH-1];
        shift_n     = {rd_word[DATA_WIDTH-2:0], 1'b0};
        valid_out_n = 1'b1;
        state_n     = S_TX;
`endif
      end
`ifdef SLAVE_WAIT_STATES_EN
      S_WAIT: begin
        if (wcnt == '0) begin
          data_out_n  = shift[DATA_WIDTH-1];
          shift_n     = {shift[DATA_WIDTH-2:0], 1'b0};
          valid_out_n = 1'b1;
          state_n     = S_TX;
        end else begin
          wcnt_n = wcnt - 1'b1;
        end
      end
`endif
      S_TX: begin
        // cnt counts bits presented beyond the first; a bit presented while
        // bus_ready was low was not taken and is re-presented unchanged.
        if (bus_ready) begin
          if (valid_out) begin
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state_n = S_IDLE;
            end else begin
              data_out_n  = shift[DATA_WIDTH-1];
              shift_n     = {shift[DATA_WIDTH-2:0], 1'b0};
              valid_out_n = 1'b1;
              cnt_n       = cnt + 1'b1;
            end
          end else begin
            valid_out_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (state_n != state) begin
      cnt_n = '0;
    end
    ready_n = (state_n == S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      shift     <= '0;
      op_wr     <= 1'b0;
      ready     <= 1'b1;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
`ifdef SLAVE_WAIT_STATES_EN
      wcnt      <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr      <= addr_n;
      shift     <= shift_n;
      op_wr     <= op_wr_n;
      ready     <= ready_n;
      data_out  <= data_out_n;
      valid_out <= valid_out_n;
`ifdef SLAVE_WAIT_STATES_EN
      wcnt      <= wcnt_n;
`endif
    end
  end

  // Register memory; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      mem[addr] <= shift;
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed self-checking bench for serial_slave_port.
module tb_serial_slave_port;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic address   = 1'b0;
  logic data      = 1'b0;
  logic valid     = 1'b0;
  logic write_en  = 1'b0;
  logic bus_ready = 1'b1;
  logic ready;
  logic data_out;
  logic valid_out;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SLAVE_WAIT_STATES_EN
  localparam int EXP_LAT = 18;
`else
  localparam int EXP_LAT = 2;
`endif

  // Results of the last transaction helpers.
  logic [7:0] word;
  int         nbits, lat, span, zeros;
  bit         fell, low_ok, gap_ok, end_ok, rose, saw_vo;

  serial_slave_port #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .WAIT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .address(address), .data(data), .valid(valid),
    .write_en(write_en), .bus_ready(bus_ready), .ready(ready),
    .data_out(data_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic a, input logic d, input logic we);
    address = a; data = d; write_en = we; valid = 1'b1; bus_ready = 1'b1;
    step();
  endtask

  // Write transaction; counts cycles with ready low until it returns high.
  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int gap_after,
                          input int gap_len, input bit drop_we);
    zeros = 0; rose = 0; saw_vo = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 6) send_beat(a[5-i], ~a[5-i], (i == 0) ? 1'b1 : ~drop_we);
      else       send_beat(~d[13-i], d[13-i], ~drop_we);
      if (valid_out) saw_vo = 1;
      if (!rose) begin if (ready) rose = 1; else zeros++; end
      if (i == gap_after) begin
        valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          address = ~address; data = ~data;
          step();
          if (valid_out) saw_vo = 1;
          if (!rose) begin if (ready) rose = 1; else zeros++; end
        end
      end
    end
    valid = 1'b0;
    for (int c = 0; c < 40 && !rose; c++) begin
      step();
      if (valid_out) saw_vo = 1;
      if (ready) rose = 1; else zeros++;
    end
  endtask

  // Read transaction; collects bits taken (valid_out && bus_ready).
  task automatic do_read(input logic [5:0] a, input int split_after, input int split_len);
    int cyc, gap, g, last;
    logic held;
    word = '0; nbits = 0; lat = -1; span = 0;
    fell = 0; low_ok = 1; gap_ok = 1; end_ok = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat(a[5-i], ~a[5-i], 1'b0);
      if (i == 0) fell = (ready === 1'b0);
    end
    valid = 1'b0; bus_ready = 1'b1;
    cyc = 0; gap = 0; g = 0; last = 0; held = 1'b0;
    while (nbits < 8 && cyc < 200) begin
      step(); cyc++;
      if (gap > 0) begin
        bus_ready = 1'b0;
        if (g == 0) held = data_out;
        else if (valid_out !== 1'b0 || data_out !== held) gap_ok = 0;
        g++; gap--;
      end else begin
        bus_ready = 1'b1;
      end
      if (ready !== 1'b0) low_ok = 0;
      if (valid_out === 1'b1 && lat < 0) lat = cyc;
      if (valid_out === 1'b1 && bus_ready === 1'b1) begin
        word = {word[6:0], data_out}; nbits++; last = cyc;
        if (nbits == split_after) gap = split_len;
      end
    end
    span = (lat < 0) ? 0 : last - lat + 1;
    bus_ready = 1'b1;
    step();
    end_ok = (ready === 1'b1 && valid_out === 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    n_cmp++; if (data_out !== 1'b0) begin n_fail++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_readback();
    do_write(6'h2A, 8'hA5, -1, 0, 0);
    n_cmp++; if (zeros != 15 || !rose) begin n_fail++; $display("FAIL write_ready_low: got %0d cycles (rose=%0d) expected 15", zeros, rose); end
    n_cmp++; if (saw_vo) begin n_fail++; $display("FAIL write_no_valid_out: valid_out seen during write"); end
    do_read(6'h2A, -1, 0);
    n_cmp++; if (word !== 8'hA5 || nbits != 8) begin n_fail++; $display("FAIL read_data: got %h (%0d bits) expected a5", word, nbits); end
    n_cmp++; if (lat != EXP_LAT) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, EXP_LAT); end
    n_cmp++; if (span != 8) begin n_fail++; $display("FAIL read_contiguous: got span %0d expected 8", span); end
    n_cmp++; if (!fell || !low_ok) begin n_fail++; $display("FAIL read_ready_low: fell=%0d low=%0d expected 1 1", fell, low_ok); end
    n_cmp++; if (!end_ok) begin n_fail++; $display("FAIL read_ready_end: ready=%b valid_out=%b expected 1 0", ready, valid_out); end
  endtask

  task automatic test_gapped_write();
    do_write(6'h01, 8'h3C, 3, 3, 0);
    n_cmp++; if (zeros != 18 || !rose) begin n_fail++; $display("FAIL gapped_ready_low: got %0d cycles expected 18", zeros); end
    do_read(6'h01, -1, 0);
    n_cmp++; if (word !== 8'h3C || nbits != 8) begin n_fail++; $display("FAIL gapped_readback: got %h expected 3c", word); end
  endtask

  task automatic test_split_tx();
    do_read(6'h2A, 3, 5);
    n_cmp++; if (word !== 8'hA5 || nbits != 8) begin n_fail++; $display("FAIL split_data: got %h (%0d bits) expected a5", word, nbits); end
    n_cmp++; if (!gap_ok) begin n_fail++; $display("FAIL split_hold: valid_out/data_out not held during gap"); end
    n_cmp++; if (span != 14) begin n_fail++; $display("FAIL split_span: got %0d expected 14", span); end
    n_cmp++; if (!end_ok) begin n_fail++; $display("FAIL split_ready_end: ready=%b valid_out=%b expected 1 0", ready, valid_out); end
  endtask

  task automatic test_reset_mid_write();
    logic [13:0] bits;
    bits = {6'h2A, 8'hFF};
    for (int i = 0; i < 10; i++) send_beat(bits[13-i], bits[13-i], 1'b1);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midwrite_busy: got ready %b expected 0", ready); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1 || valid_out !== 1'b0) begin n_fail++; $display("FAIL midwrite_reset: ready=%b valid_out=%b expected 1 0", ready, valid_out); end
    valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    do_read(6'h2A, -1, 0);
    n_cmp++; if (word !== 8'hA5) begin n_fail++; $display("FAIL midwrite_preserved: got %h expected a5", word); end
  endtask

  task automatic test_write_en_toggle();
    bit vo_any;
    do_write(6'h15, 8'h5A, -1, 0, 1);
    vo_any = saw_vo;
    for (int c = 0; c < 10; c++) begin
      step();
      if (valid_out) vo_any = 1;
    end
    n_cmp++; if (zeros != 15 || !rose) begin n_fail++; $display("FAIL weflip_ready_low: got %0d expected 15", zeros); end
    n_cmp++; if (vo_any) begin n_fail++; $display("FAIL weflip_no_read: valid_out seen, expected none"); end
    do_read(6'h15, -1, 0);
    n_cmp++; if (word !== 8'h5A) begin n_fail++; $display("FAIL weflip_readback: got %h expected 5a", word); end
  endtask

  task automatic test_idle_blocked();
    bit stayed;
    stayed = 1;
    valid = 1'b1; bus_ready = 1'b0; write_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      address = ~address; data = ~data;
      step();
      if (ready !== 1'b1 || valid_out !== 1'b0) stayed = 0;
    end
    valid = 1'b0; bus_ready = 1'b1;
    step();
    n_cmp++; if (!stayed) begin n_fail++; $display("FAIL blocked_idle: ready left 1 with bus_ready low"); end
    do_read(6'h2A, -1, 0);
    n_cmp++; if (word !== 8'hA5) begin n_fail++; $display("FAIL blocked_readback: got %h expected a5", word); end
  endtask

  task automatic test_back_to_back();
    do_write(6'h3F, 8'hC3, -1, 0, 0);
    n_cmp++; if (zeros != 15 || !rose) begin n_fail++; $display("FAIL b2b_write: got %0d expected 15", zeros); end
    do_read(6'h3F, -1, 0);
    n_cmp++; if (!fell) begin n_fail++; $display("FAIL b2b_start: ready did not fall after immediate beat"); end
    n_cmp++; if (word !== 8'hC3) begin n_fail++; $display("FAIL b2b_readback: got %h expected c3", word); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_gapped_write();
    test_split_tx();
    test_reset_mid_write();
    test_write_en_toggle();
    test_idle_blocked();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

- Slave-side responder of the serial master/slave bus.
- Sits behind each slave connection of the bus arbiter.
- Deserialises the address and write data shifted in by the granted master, and performs a write to or read from a local register memory.
- Serialises read data back through the arbiter, with `ready` flow control and pausing whenever the arbiter has lent the bus elsewhere during a split transaction.

## Interface
- `ADDR_WIDTH`, 6, local memory address bits (depth 2^ADDR_WIDTH).
- `DATA_WIDTH`, 8, bits per memory word.
- `WAIT_CYCLES`, 16, read wait states (used only with `SLAVE_WAIT_STATES_EN`).
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `address`  in  1  serial address bit from the arbiter.
- `data`  in  1  serial write-data bit from the arbiter.
- `valid`  in  1  qualifies `address`/`data` this cycle.
- `write_en`  in  1  1 = write, 0 = read; sampled with the first address bit.
- `bus_ready`  in  1  arbiter is not currently routing another slave; gates all sampling and transmission.
- `ready`  out  1  1 = idle and able to accept a transaction.
- `data_out`  out  1  serial read-data bit to the arbiter.
- `valid_out`  out  1  qualifies `data_out`.

## Operation
- Accepted beat = rising edge with `valid && bus_ready`. Non-accepted cycles never advance any counter.
- All serial fields are MSB first. Bit counter is `$clog2(max(ADDR_WIDTH,DATA_WIDTH))+1` bits wide and clears on every state change.
- Memory: 2^ADDR_WIDTH x DATA_WIDTH registers. Memory is not reset; its contents are undefined until written.
- State transitions:
  - IDLE -> RX_ADDR on an accepted beat. That beat stores address bit ADDR_WIDTH-1 and latches `write_en` as `op_wr`.
  - RX_ADDR shifts one bit per accepted beat. After ADDR_WIDTH total bits: `op_wr`=1 -> RX_DATA, else -> READ.
  - RX_DATA shifts `data` per accepted beat. After DATA_WIDTH bits -> WRITE.
  - WRITE: one cycle, `mem[addr] <= shift`, then -> IDLE.
  - READ: one cycle, loads `mem[addr]` into the TX shift register. Then -> TX, or -> WAIT when the macro is enabled.
  - WAIT: counts down WAIT_CYCLES clocks regardless of `bus_ready`, then -> TX.
  - TX: each cycle with `bus_ready`=1 presents the next bit. After DATA_WIDTH bits sent -> IDLE.
- `ready` = (state == IDLE), registered.
- A transaction left incomplete (`valid` dropped, or a split) is held indefinitely; no timeout. Only reset aborts it.
- Simultaneous `valid`=1 and `bus_ready`=0 in IDLE: ignored, stays IDLE.
- `write_en` changes after the first beat are ignored.

## Timing
- Reset values: `ready`=1, `data_out`=0, `valid_out`=0, state IDLE, counters 0. These apply immediately on reset assertion.
- Reset mid-operation: any partial write is discarded and memory is not modified. A WRITE cycle already completed persists.
- `ready` falls the cycle after the first accepted beat.
- Write latency:
  - `ready` returns 1 on the second edge after the last data beat (WRITE, then IDLE).
  - Total for uninterrupted beats: ADDR_WIDTH+DATA_WIDTH+2 cycles from the first beat.
- Read latency:
  - Edge after the last address beat: READ.
  - Next edge: first `data_out`/`valid_out`=1, registered.
  - Bits are held one cycle each. `valid_out` is 1 only in cycles where a bit is presented.
- `bus_ready`=0 during TX: `valid_out` drops to 0 next cycle and `data_out` holds its bit. The same bit is re-presented when `bus_ready` returns; no bit is skipped.
- `ready` rises the cycle after the last TX bit is presented, with `valid_out`=0 in that cycle.
- Back-to-back: a beat on the same edge `ready` is observed 1 starts a new transaction.

## Configuration
- `SLAVE_WAIT_STATES_EN` defined:
  - READ -> WAIT -> TX.
  - First `valid_out` arrives WAIT_CYCLES+2 cycles after the last address beat.
  - `ready` stays 0 throughout.
  - The WAIT_CYCLES default of 16 exceeds the arbiter's split threshold (12), so this provokes splits for test.
- Undefined: the WAIT state and its counter are not compiled, and READ goes directly to TX.

## Test plan
- Write, then read back:
  - Write: addr 6'h2A, data 8'hA5, `write_en`=1, 14 uninterrupted beats. Expect `ready` 0 for 15 cycles, then 1, and `mem[42]`=8'hA5.
  - Read: addr 6'h2A, `write_en`=0. Expect `valid_out` high 8 consecutive cycles with `data_out` 1,0,1,0,0,1,0,1, then `ready`=1 the following cycle.
- Gapped write: drop `valid` for 3 cycles after address bit 3 of a write of 8'h3C to 6'h01. Expect the state held with no extra bits, and the read-back of 6'h01 returns 8'h3C.
- Split during TX:
  - Read of 8'hA5 with `bus_ready`=0 for 5 cycles after bit 2 is presented.
  - Expect `valid_out`=0 and `data_out` held during the gap.
  - Full 8-bit sequence still 1,0,1,0,0,1,0,1, with no bit lost or duplicated.
- Reset mid-write: assert `reset`=0 after 10 of 14 beats of 8'hFF to 6'h2A (previously holding 8'hA5). Expect `ready`=1 and `valid_out`=0 immediately, and a subsequent read of 6'h2A returns 8'hA5.
- Macro on, WAIT_CYCLES=16: read 6'h2A. Expect first `valid_out` 18 cycles after the last address beat, `ready`=0 throughout.
- `write_en` toggled to 0 after the first beat of a write: still treated as a write, and no `valid_out` occurs.
